// File: rtl/mem_arb_pkg.sv
// Shared widths, FSM state encoding and owner encoding for the memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam int ADDR_W  = 28;
    localparam int BLOCK_W = 128;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } arb_state_e;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the I-cache, D-cache and data-memory block ports around the arbiter.
// Latency: n/a (wires only).
// Backpressure: I_BUSYWAIT / D_BUSYWAIT toward the caches, MEM_BUSYWAIT from memory.
// Modports: slave = arbiter view, master = view of the caches and memory together.
interface mem_arbiter_if;
    import mem_arb_pkg::*;

    logic               I_READ;
    logic [ADDR_W-1:0]  I_ADDRESS;
    logic [BLOCK_W-1:0] I_READDATA;
    logic               I_BUSYWAIT;

    logic               D_READ;
    logic               D_WRITE;
    logic [ADDR_W-1:0]  D_ADDRESS;
    logic [BLOCK_W-1:0] D_WRITEDATA;
    logic [BLOCK_W-1:0] D_READDATA;
    logic               D_BUSYWAIT;

    logic               MEM_READ;
    logic               MEM_WRITE;
    logic [ADDR_W-1:0]  MEM_ADDRESS;
    logic [BLOCK_W-1:0] MEM_WRITEDATA;
    logic [BLOCK_W-1:0] MEM_READDATA;
    logic               MEM_BUSYWAIT;

    modport slave (
        input  I_READ, I_ADDRESS,
        input  D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
        input  MEM_READDATA, MEM_BUSYWAIT,
        output I_READDATA, I_BUSYWAIT,
        output D_READDATA, D_BUSYWAIT,
        output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

    modport master (
        output I_READ, I_ADDRESS,
        output D_READ, D_WRITE, D_ADDRESS, D_WRITEDATA,
        output MEM_READDATA, MEM_BUSYWAIT,
        input  I_READDATA, I_BUSYWAIT,
        input  D_READDATA, D_BUSYWAIT,
        input  MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA
    );

endinterface

// File: rtl/mem_arb_pick.sv
// Chooses the next bus owner from the I/D request bits (MEM_ARB_ROUND_ROBIN_EN selects policy).
// Latency: purely combinational.
// Backpressure: none; the caller only samples the pick while idle.
// Ports: i_req_i/d_req_i requests, last_owner_i previous grant, grant_vld_o/grant_owner_o result.
module mem_arb_pick
    import mem_arb_pkg::*;
(
    input  logic i_req_i,
    input  logic d_req_i,
    input  logic last_owner_i,
    output logic grant_vld_o,
    output logic grant_owner_o
);

    assign grant_vld_o = i_req_i | d_req_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // On a conflict the side that did not get the previous grant wins.
    always_comb begin
        if (i_req_i && d_req_i) begin
            grant_owner_o = ~last_owner_i;
        end else begin
            grant_owner_o = d_req_i ? OWN_D : OWN_I;
        end
    end
`else
    // Fixed priority: D wins every conflict, history is irrelevant.
    logic unused_last_owner;
    assign unused_last_owner = last_owner_i;
    assign grant_owner_o     = d_req_i ? OWN_D : OWN_I;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Shares one block memory between I-cache and D-cache; optional MEM_ARB_ROUND_ROBIN_EN policy.
// Latency: strobes rise one cycle after the request is seen idle; RELEASE adds one idle cycle.
// Backpressure: each requester stalls on *_BUSYWAIT until its own completion cycle.
// Ports: CLOCK, RESET (sync, active-high), bus (mem_arbiter_if.slave).
module mem_arbiter
    import mem_arb_pkg::*;
(
    input  logic         CLOCK,
    input  logic         RESET,
    mem_arbiter_if.slave bus
);

    localparam logic [1:0] S_IDLE    = ST_IDLE;
    localparam logic [1:0] S_GRANT   = ST_GRANT;
    localparam logic [1:0] S_RELEASE = ST_RELEASE;

    logic [1:0]         state_q, state_d;
    logic               owner_q, owner_d;
    logic               started_q, started_d;
    logic               last_owner_q, last_owner_d;
    logic               mem_read_q, mem_read_d;
    logic               mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
    logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [BLOCK_W-1:0] i_rdata_q, i_rdata_d;
    logic [BLOCK_W-1:0] d_rdata_q, d_rdata_d;

    logic i_req, d_req;
    logic pick_vld, pick_owner;
    logic done, done_i, done_d;

    assign i_req = bus.I_READ;
    assign d_req = bus.D_READ | bus.D_WRITE;

    mem_arb_pick u_pick (
        .i_req_i       (i_req),
        .d_req_i       (d_req),
        .last_owner_i  (last_owner_q),
        .grant_vld_o   (pick_vld),
        .grant_owner_o (pick_owner)
    );

    // Memory must have gone busy at least once before a low busywait means "finished";
    // gating with RESET lets both stalls follow the raw requests while in reset.
    assign done   = (state_q == S_GRANT) && started_q && !bus.MEM_BUSYWAIT && !RESET;
    assign done_i = done && (owner_q == OWN_I);
    assign done_d = done && (owner_q == OWN_D);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        started_d    = started_q;
        last_owner_d = last_owner_q;
        mem_read_d   = mem_read_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    state_d      = S_GRANT;
                    owner_d      = pick_owner;
                    last_owner_d = pick_owner;
                    started_d    = 1'b0;
                    if (pick_owner == OWN_D) begin
                        // A write-back wins over a read when both are raised.
                        mem_addr_d  = bus.D_ADDRESS;
                        mem_wdata_d = bus.D_WRITEDATA;
                        mem_write_d = bus.D_WRITE;
                        mem_read_d  = ~bus.D_WRITE;
                    end else begin
                        mem_addr_d  = bus.I_ADDRESS;
                        mem_wdata_d = '0;
                        mem_write_d = 1'b0;
                        mem_read_d  = 1'b1;
                    end
                end
            end
            S_GRANT: begin
                if (bus.MEM_BUSYWAIT) begin
                    started_d = 1'b1;
                end
                // Runs to completion even if the owner dropped its request.
                if (done) begin
                    state_d     = S_RELEASE;
                    started_d   = 1'b0;
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    if (mem_read_q) begin
                        if (owner_q == OWN_I) begin
                            i_rdata_d = bus.MEM_READDATA;
                        end else begin
                            d_rdata_d = bus.MEM_READDATA;
                        end
                    end
                end
            end
            S_RELEASE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_I;
            started_q    <= 1'b0;
            last_owner_q <= OWN_D;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            i_rdata_q    <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            started_q    <= started_d;
            last_owner_q <= last_owner_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign bus.MEM_READ      = mem_read_q;
    assign bus.MEM_WRITE     = mem_write_q;
    assign bus.MEM_ADDRESS   = mem_addr_q;
    assign bus.MEM_WRITEDATA = mem_wdata_q;

    assign bus.I_BUSYWAIT = i_req && !done_i;
    assign bus.D_BUSYWAIT = d_req && !done_d;

    // Forward memory data in the completion cycle, then hold the captured copy.
    assign bus.I_READDATA = (done_i && mem_read_q) ? bus.MEM_READDATA : i_rdata_q;
    assign bus.D_READDATA = (done_d && mem_read_q) ? bus.MEM_READDATA : d_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a busywait memory model and a transaction scoreboard.
// Latency: memory holds busywait for 5 cycles after it sees a strobe.
// Backpressure: cache requests are held until the matching busywait drops.
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    localparam int LAT = 5;

    typedef struct packed {
        logic               wr;
        logic [ADDR_W-1:0]  addr;
        logic [BLOCK_W-1:0] wdata;
    } txn_t;

    logic CLOCK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLOCK = ~CLOCK;

    mem_arbiter_if bus();

    mem_arbiter dut (
        .CLOCK (CLOCK),
        .RESET (RESET),
        .bus   (bus)
    );

    int   n_total = 0;
    int   n_pass  = 0;
    int   n_fail  = 0;
    txn_t exp_q[$];
    bit   last_own = OWN_D;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // ---------------- memory model ----------------
    bit               m_busy = 1'b0;
    bit               m_hold = 1'b0;
    int               m_cnt  = 0;
    bit [BLOCK_W-1:0] m_rdata = '0;
    bit               written [16];
    bit [BLOCK_W-1:0] wr_data [16];

    assign bus.MEM_BUSYWAIT = m_busy;
    assign bus.MEM_READDATA = m_rdata;

    function automatic logic [127:0] rd_model(input logic [27:0] a);
        if (written[a[7:4]]) return wr_data[a[7:4]];
        if (a == 28'h10) return {16{8'hA5}};
        return {4{4'h0, a}};
    endfunction

    always @(posedge CLOCK) begin
        if (RESET) begin
            m_busy <= 1'b0;
            m_hold <= 1'b0;
            m_cnt  <= 0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_hold <= 1'b1;
                if (bus.MEM_WRITE) begin
                    written[bus.MEM_ADDRESS[7:4]] <= 1'b1;
                    wr_data[bus.MEM_ADDRESS[7:4]] <= bus.MEM_WRITEDATA;
                end else begin
                    m_rdata <= rd_model(bus.MEM_ADDRESS);
                end
            end else begin
                m_cnt <= m_cnt - 1;
            end
        end else if (m_hold) begin
            if (!(bus.MEM_READ || bus.MEM_WRITE)) m_hold <= 1'b0;
        end else if (bus.MEM_READ || bus.MEM_WRITE) begin
            m_busy <= 1'b1;
            m_cnt  <= LAT - 1;
        end
    end

    // ---------------- scoreboard monitor ----------------
    logic prev_strobe = 1'b0;
    always @(negedge CLOCK) begin : mon
        logic strobe;
        txn_t e;
        strobe = bus.MEM_READ | bus.MEM_WRITE;
        if (strobe && !prev_strobe) begin
            check("txn_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("mem_write", bus.MEM_WRITE, e.wr);
                check("mem_read", bus.MEM_READ, !e.wr);
                check("mem_addr", bus.MEM_ADDRESS, e.addr);
                if (e.wr) check("mem_wdata", bus.MEM_WRITEDATA, e.wdata);
            end
        end
        prev_strobe <= strobe;
    end

    // ---------------- helpers ----------------
    task automatic push(input bit is_d, input bit wr, input logic [27:0] a, input logic [127:0] wd);
        txn_t t;
        t.wr = wr;
        t.addr = a;
        t.wdata = wd;
        exp_q.push_back(t);
        last_own = is_d;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge CLOCK);
    endtask

    task automatic wait_bw_low(input bit is_d, output int cyc);
        cyc = 0;
        do begin
            @(negedge CLOCK);
            cyc++;
        end while ((is_d ? bus.D_BUSYWAIT : bus.I_BUSYWAIT) && cyc < 40);
    endtask

    task automatic conflict(input logic [27:0] ai, input logic [27:0] ad, input string tag);
        int cyc;
        bit d_first;
`ifdef MEM_ARB_ROUND_ROBIN_EN
        d_first = (last_own == OWN_I);
`else
        d_first = 1'b1;
`endif
        bus.I_ADDRESS = ai;
        bus.D_ADDRESS = ad;
        bus.I_READ    = 1'b1;
        bus.D_READ    = 1'b1;
        if (d_first) begin
            push(OWN_D, 1'b0, ad, '0);
            push(OWN_I, 1'b0, ai, '0);
        end else begin
            push(OWN_I, 1'b0, ai, '0);
            push(OWN_D, 1'b0, ad, '0);
        end
        wait_bw_low(d_first, cyc);
        check({tag, "_first_lat"}, cyc, 7);
        check({tag, "_loser_bw"}, d_first ? bus.I_BUSYWAIT : bus.D_BUSYWAIT, 1);
        check({tag, "_first_rdata"}, d_first ? bus.D_READDATA : bus.I_READDATA,
              rd_model(d_first ? ad : ai));
        if (d_first) bus.D_READ = 1'b0;
        else         bus.I_READ = 1'b0;
        wait_bw_low(!d_first, cyc);
        check({tag, "_second_lat"}, cyc, 9);
        check({tag, "_second_rdata"}, d_first ? bus.I_READDATA : bus.D_READDATA,
              rd_model(d_first ? ai : ad));
        bus.I_READ = 1'b0;
        bus.D_READ = 1'b0;
        tick(2);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int cyc;
        logic [127:0] a5;
        logic [127:0] wd;
        a5 = {16{8'hA5}};
        wd = {32'h12345678, 32'h9ABCDEF0, 32'h0F1E2D3C, 32'h4B5A6978};

        bus.I_READ      = 1'b0;
        bus.I_ADDRESS   = '0;
        bus.D_READ      = 1'b0;
        bus.D_WRITE     = 1'b0;
        bus.D_ADDRESS   = '0;
        bus.D_WRITEDATA = '0;
        RESET = 1'b1;
        tick(2);

        // Stall follows the request while reset is held.
        bus.I_READ = 1'b1;
        #1 check("rst_i_bw_follow", bus.I_BUSYWAIT, 1);
        bus.I_READ = 1'b0;
        #1 check("rst_i_bw_idle", bus.I_BUSYWAIT, 0);
        tick(1);
        RESET = 1'b0;
        check("rst_mem_read", bus.MEM_READ, 0);
        check("rst_mem_write", bus.MEM_WRITE, 0);
        check("rst_mem_addr", bus.MEM_ADDRESS, 0);
        check("rst_mem_wdata", bus.MEM_WRITEDATA, 0);
        check("rst_i_rdata", bus.I_READDATA, 0);
        check("rst_d_rdata", bus.D_READDATA, 0);

        // Single I read.
        bus.I_ADDRESS = 28'h10;
        bus.I_READ    = 1'b1;
        push(OWN_I, 1'b0, 28'h10, '0);
        tick(1);
        check("t1_mem_read", bus.MEM_READ, 1);
        check("t1_i_bw", bus.I_BUSYWAIT, 1);
        wait_bw_low(1'b0, cyc);
        check("t1_latency", cyc, 6);
        check("t1_i_rdata", bus.I_READDATA, a5);
        check("t1_d_bw", bus.D_BUSYWAIT, 0);
        bus.I_READ = 1'b0;
        tick(1);
        check("t1_release_strobe", bus.MEM_READ, 0);
        check("t1_rdata_hold", bus.I_READDATA, a5);
        tick(1);

        // D write-back with read also raised.
        bus.D_ADDRESS   = 28'h20;
        bus.D_WRITEDATA = wd;
        bus.D_READ      = 1'b1;
        bus.D_WRITE     = 1'b1;
        push(OWN_D, 1'b1, 28'h20, wd);
        tick(1);
        check("t2_mem_write", bus.MEM_WRITE, 1);
        check("t2_mem_read", bus.MEM_READ, 0);
        wait_bw_low(1'b1, cyc);
        check("t2_latency", cyc, 6);
        check("t2_i_bw", bus.I_BUSYWAIT, 0);
        bus.D_READ  = 1'b0;
        bus.D_WRITE = 1'b0;
        tick(2);

        // Repeated conflicts from a fresh reset.
        RESET = 1'b1;
        tick(1);
        RESET = 1'b0;
        last_own = OWN_D;
        conflict(28'h30, 28'h40, "c1");
        conflict(28'h50, 28'h60, "c2");
        conflict(28'h70, 28'h80, "c3");

        // I arrives during the third cycle of D's grant.
        bus.D_ADDRESS = 28'h50;
        bus.D_READ    = 1'b1;
        push(OWN_D, 1'b0, 28'h50, '0);
        tick(3);
        bus.I_ADDRESS = 28'h60;
        bus.I_READ    = 1'b1;
        push(OWN_I, 1'b0, 28'h60, '0);
        wait_bw_low(1'b1, cyc);
        check("t4_d_lat", cyc, 4);
        check("t4_i_bw_done", bus.I_BUSYWAIT, 1);
        bus.D_READ = 1'b0;
        tick(1);
        check("t4_i_bw_release", bus.I_BUSYWAIT, 1);
        check("t4_release_strobe", bus.MEM_READ, 0);
        tick(1);
        check("t4_i_bw_idle", bus.I_BUSYWAIT, 1);
        check("t4_idle_strobe", bus.MEM_READ, 0);
        tick(1);
        check("t4_i_grant", bus.MEM_READ, 1);
        wait_bw_low(1'b0, cyc);
        check("t4_i_lat", cyc, 6);
        check("t4_i_rdata", bus.I_READDATA, rd_model(28'h60));
        bus.I_READ = 1'b0;
        tick(2);

        // Reset pulse mid-grant with the request held.
        bus.D_ADDRESS = 28'h70;
        bus.D_READ    = 1'b1;
        push(OWN_D, 1'b0, 28'h70, '0);
        tick(3);
        RESET = 1'b1;
        #1 check("t5_rst_d_bw", bus.D_BUSYWAIT, 1);
        tick(1);
        RESET = 1'b0;
        push(OWN_D, 1'b0, 28'h70, '0);
        check("t5_mem_read", bus.MEM_READ, 0);
        check("t5_mem_addr", bus.MEM_ADDRESS, 0);
        check("t5_i_rdata", bus.I_READDATA, 0);
        check("t5_d_rdata", bus.D_READDATA, 0);
        check("t5_d_bw", bus.D_BUSYWAIT, 1);
        tick(1);
        check("t5_regrant", bus.MEM_READ, 1);
        wait_bw_low(1'b1, cyc);
        check("t5_lat", cyc, 6);
        check("t5_d_rdata_done", bus.D_READDATA, rd_model(28'h70));
        bus.D_READ = 1'b0;
        tick(2);

        // D withdraws its read mid-grant; the stored write-back comes back.
        bus.D_ADDRESS = 28'h20;
        bus.D_READ    = 1'b1;
        push(OWN_D, 1'b0, 28'h20, '0);
        tick(3);
        bus.D_READ = 1'b0;
        #1 check("t6_d_bw_drop", bus.D_BUSYWAIT, 0);
        cyc = 0;
        do begin
            @(negedge CLOCK);
            cyc++;
        end while (bus.MEM_READ && cyc < 40);
        check("t6_strobe_fall", cyc, 5);
        check("t6_d_rdata", bus.D_READDATA, wd);
        tick(6);
        check("t6_no_retry", bus.MEM_READ, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
